draw_request_arbiter: RTL and testbench

// - Shares the single DrawMif LCD draw engine among NUM_REQ independent draw requesters
//   (background, floor tiles, player sprite, obstacle, overlays).
// - Round-robin arbitration; latches the winner's origin/ROM id and runs the engine

---
 rtl/draw_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/draw_request_arbiter.sv | 167 ++++++++++++++++
 tb/tb_draw_request_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared definitions for the draw request arbiter.
// - draw_state_e : arbiter FSM state encoding
// - default origin / ROM id widths
// - ROM ids of the fixed full-screen images
package draw_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StWaitReady,
    StRelease,
    StGap
  } draw_state_e;

  localparam int unsigned DEF_X_WIDTH  = 8;
  localparam int unsigned DEF_Y_WIDTH  = 9;
  localparam int unsigned DEF_ID_WIDTH = 4;

  localparam logic [DEF_ID_WIDTH-1:0] ROM_ID_BACKGROUND = 4'd11;
  localparam logic [DEF_ID_WIDTH-1:0] ROM_ID_FLOOR      = 4'd5;
  localparam logic [DEF_ID_WIDTH-1:0] ROM_ID_GAME_OVER  = 4'd10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req    in  NUM_REQ      request vector
//   ptr    in  IDX_W        highest-priority index this round
//   onehot out NUM_REQ      one-hot winner (0 when none)
//   idx    out IDX_W        winner index (0 when none)
//   any    out 1            at least one request set
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int unsigned j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Scan from ptr upwards, wrapping; the first hit wins.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_request_arbiter.sv
// Shares the single DrawMif LCD draw engine among NUM_REQ requesters.
// Round-robin grant, latches origin/ROM id, runs the draw/ready handshake and
// returns a one-cycle ack to the served requester.
// Ports:
//   clock, reset        clock, async active-high reset
//   req                 level requests, held until ack
//   req_x/req_y/req_id  packed per-requester origin and ROM id
//   ack                 one-hot one-cycle pulse when a draw finishes
//   busy                high whenever not idle
//   grant_idx           current/last granted requester
//   timeout_err         sticky, set on a forced abort
//   draw, x_origin, y_origin, rom_id   to engine
//   ready               from engine
module draw_request_arbiter
  import draw_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned X_WIDTH         = DEF_X_WIDTH,
  parameter int unsigned Y_WIDTH         = DEF_Y_WIDTH,
  parameter int unsigned ID_WIDTH        = DEF_ID_WIDTH,
  parameter int unsigned MIN_DRAW_CYCLES = 21,
  parameter int unsigned TIMEOUT_CYCLES  = 4000000,
  localparam int unsigned IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*Y_WIDTH-1:0]   req_y,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  req_id,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         timeout_err,
  output logic                         draw,
  output logic [X_WIDTH-1:0]           x_origin,
  output logic [Y_WIDTH-1:0]           y_origin,
  output logic [ID_WIDTH-1:0]          rom_id,
  input  logic                         ready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DRAW_END = CNT_W'(MIN_DRAW_CYCLES - 1);

  draw_state_e          state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 draw_q, draw_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [CNT_W-1:0]     count_inc;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    count_d   = count_q;
    draw_d    = draw_q;
    timeout_d = timeout_q;
    ack_d     = '0;
    x_d       = x_q;
    y_d       = y_q;
    id_d      = id_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d = pick_idx;
          x_d     = req_x[pick_idx*X_WIDTH +: X_WIDTH];
          y_d     = req_y[pick_idx*Y_WIDTH +: Y_WIDTH];
          id_d    = req_id[pick_idx*ID_WIDTH +: ID_WIDTH];
          draw_d  = 1'b1;
          // The grant cycle itself is the first cycle counted with draw high.
          count_d = CNT_W'(1);
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (count_q == DRAW_END) begin
          count_d = '0;
          state_d = StWaitReady;
        end else begin
          count_d = count_inc;
        end
      end
      StWaitReady: begin
        if (ready) begin
          draw_d  = 1'b0;
          state_d = StRelease;
        end else if (count_q == CNT_MAX) begin
          draw_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = StRelease;
        end else begin
          count_d = count_inc;
        end
      end
      StRelease: begin
        ack_d[grant_q] = 1'b1;
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        count_d = '0;
        state_d = StGap;
      end
      StGap: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      count_q   <= '0;
      draw_q    <= 1'b0;
      timeout_q <= 1'b0;
      ack_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      count_q   <= count_d;
      draw_q    <= draw_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
      x_q       <= x_d;
      y_q       <= y_d;
      id_q      <= id_d;
    end
  end

  assign ack         = ack_q;
  assign busy        = (state_q != StIdle);
  assign grant_idx   = grant_q;
  assign timeout_err = timeout_q;
  assign draw        = draw_q;
  assign x_origin    = x_q;
  assign y_origin    = y_q;
  assign rom_id      = id_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Directed bench for draw_request_arbiter: one instance with default timeout,
// one with a short timeout for the abort scenario.
module tb_draw_request_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_x = '0;
  logic [35:0] req_y = '0;
  logic [15:0] req_id = '0;
  logic        ready = 1'b1;
  logic [3:0]  ack;
  logic        busy, timeout_err, draw;
  logic [1:0]  grant_idx;
  logic [7:0]  x_origin;
  logic [8:0]  y_origin;
  logic [3:0]  rom_id;

  logic [3:0]  req_t = '0;
  logic [31:0] req_x_t = '0;
  logic [35:0] req_y_t = '0;
  logic [15:0] req_id_t = '0;
  logic        ready_t = 1'b0;
  logic [3:0]  ack_t;
  logic        busy_t, timeout_err_t, draw_t;
  logic [1:0]  grant_idx_t;
  logic [7:0]  x_origin_t;
  logic [8:0]  y_origin_t;
  logic [3:0]  rom_id_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  draw_request_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_id(req_id), .ack(ack), .busy(busy), .grant_idx(grant_idx),
    .timeout_err(timeout_err), .draw(draw), .x_origin(x_origin),
    .y_origin(y_origin), .rom_id(rom_id), .ready(ready)
  );

  draw_request_arbiter #(.TIMEOUT_CYCLES(64)) dut_t (
    .clock(clock), .reset(reset), .req(req_t), .req_x(req_x_t), .req_y(req_y_t),
    .req_id(req_id_t), .ack(ack_t), .busy(busy_t), .grant_idx(grant_idx_t),
    .timeout_err(timeout_err_t), .draw(draw_t), .x_origin(x_origin_t),
    .y_origin(y_origin_t), .rom_id(rom_id_t), .ready(ready_t)
  );

  task automatic set_slot(input int i, input logic [7:0] x, input logic [8:0] y,
                          input logic [3:0] id);
    req_x[i*8 +: 8]  = x;
    req_y[i*9 +: 9]  = y;
    req_id[i*4 +: 4] = id;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || busy_t) && k < 200) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({draw, busy, ack, grant_idx, timeout_err, x_origin, y_origin, rom_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: draw=%b busy=%b ack=%b idx=%0d terr=%b x=%0d y=%0d id=%0d, required all 0",
               draw, busy, ack, grant_idx, timeout_err, x_origin, y_origin, rom_id);
    end
    n_checks++;
    if ({draw_t, busy_t, ack_t, timeout_err_t} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_t: draw=%b busy=%b ack=%b terr=%b, required 0",
               draw_t, busy_t, ack_t, timeout_err_t);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int cnt = 0;
    int bad = 0;
    ready = 1'b1;
    set_slot(2, 8'd100, 9'd119, 4'd1);
    req = 4'b0100;
    @(negedge clock);
    n_checks++;
    if (draw !== 1'b1) begin
      n_fail++;
      $display("FAIL single_draw_rise: draw=%b, required 1", draw);
    end
    while (draw === 1'b1 && cnt < 100) begin
      if (x_origin !== 8'd100 || y_origin !== 9'd119 || rom_id !== 4'd1) bad++;
      cnt++;
      @(negedge clock);
    end
    n_checks++;
    if (cnt != 21) begin
      n_fail++;
      $display("FAIL single_draw_len: %0d cycles, required 21", cnt);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL single_origin: %0d bad cycles, required 0", bad);
    end
    n_checks++;
    if (grant_idx !== 2'd2 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_release: idx=%0d ack=%b, required 2 and 0000", grant_idx, ack);
    end
    @(negedge clock);
    n_checks++;
    if (ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b, required 0100", ack);
    end
    req = 4'b0000;
    @(negedge clock);
    n_checks++;
    if (ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_ack_pulse: ack=%b, required 0000", ack);
    end
    wait_idle();
  endtask

  task automatic test_slow_engine();
    ready = 1'b0;
    set_slot(1, 8'd20, 9'd30, 4'd5);
    req = 4'b0010;
    @(negedge clock);
    n_checks++;
    if (draw !== 1'b1 || grant_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL slow_grant: draw=%b idx=%0d, required 1 and 1", draw, grant_idx);
    end
    repeat (499) @(negedge clock);
    n_checks++;
    if (draw !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL slow_hold: draw=%b busy=%b at cycle 500, required 1 1", draw, busy);
    end
    ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (draw !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_fall: draw=%b, required 0", draw);
    end
    @(negedge clock);
    n_checks++;
    if (ack !== 4'b0010 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_ack: ack=%b terr=%b, required 0010 and 0", ack, timeout_err);
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    int k = 0;
    ready_t = 1'b0;
    req_x_t[24 +: 8] = 8'd9;
    req_t = 4'b1000;
    @(negedge clock);
    n_checks++;
    if (draw_t !== 1'b1 || timeout_err_t !== 1'b0) begin
      n_fail++;
      $display("FAIL to_grant: draw=%b terr=%b, required 1 and 0", draw_t, timeout_err_t);
    end
    while (draw_t === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clock);
    end
    n_checks++;
    if (cnt < 64 || cnt >= 300) begin
      n_fail++;
      $display("FAIL to_abort: draw high %0d cycles, required between 64 and 299", cnt);
    end
    n_checks++;
    if (timeout_err_t !== 1'b1) begin
      n_fail++;
      $display("FAIL to_err_set: terr=%b, required 1", timeout_err_t);
    end
    @(negedge clock);
    n_checks++;
    if (ack_t !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_ack: ack=%b, required 1000", ack_t);
    end
    req_t = 4'b0001;
    ready_t = 1'b1;
    while (draw_t !== 1'b1 && k < 10) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (draw_t !== 1'b1 || grant_idx_t !== 2'd0) begin
      n_fail++;
      $display("FAIL to_next_grant: draw=%b idx=%0d, required 1 and 0", draw_t, grant_idx_t);
    end
    k = 0;
    while (draw_t === 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    n_checks++;
    if (ack_t !== 4'b0001 || timeout_err_t !== 1'b1) begin
      n_fail++;
      $display("FAIL to_next_ack: ack=%b terr=%b, required 0001 and 1", ack_t, timeout_err_t);
    end
    req_t = 4'b0000;
    wait_idle();
  endtask

  task automatic test_round_robin();
    int got[5];
    int n = 0;
    int k = 0;
    bit reraise = 1'b0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 8'(i * 10), 9'(i * 20), 4'(i));
    ready = 1'b1;
    req = 4'b1111;
    while (n < 5 && k < 400) begin
      @(negedge clock);
      k++;
      if (reraise) begin
        req[0] = 1'b1;
        reraise = 1'b0;
      end
      if (ack !== 4'b0000) begin
        for (int b = 0; b < 4; b++) if (ack[b]) got[n] = b;
        req = req & ~ack;
        if (n == 0) reraise = 1'b1;
        n++;
      end
    end
    n_checks++;
    if (n != 5) begin
      n_fail++;
      $display("FAIL rr_ack_count: %0d acks, required 5", n);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (got[i] != exp_order[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: requester %0d, required %0d", i, got[i], exp_order[i]);
      end
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_reset_mid_draw();
    int k = 0;
    ready = 1'b1;
    req = 4'b1001;
    @(negedge clock);
    n_checks++;
    if (draw !== 1'b1 || grant_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_grant: draw=%b idx=%0d, required 1 and 3", draw, grant_idx);
    end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (draw !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_async: draw=%b busy=%b ack=%b, required 0 0 0000", draw, busy, ack);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (draw !== 1'b1 || grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_first_grant: draw=%b idx=%0d, required 1 and 0", draw, grant_idx);
    end
    while (ack === 4'b0000 && k < 100) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_first_ack: ack=%b, required 0001", ack);
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_input_churn();
    int bad = 0;
    int k = 0;
    ready = 1'b1;
    set_slot(2, 8'd33, 9'd44, 4'd5);
    req = 4'b0100;
    @(negedge clock);
    n_checks++;
    if (draw !== 1'b1) begin
      n_fail++;
      $display("FAIL churn_grant: draw=%b, required 1", draw);
    end
    while (draw === 1'b1 && k < 100) begin
      req_x[16 +: 8] = 8'($urandom);
      req_y[18 +: 9] = 9'($urandom);
      req_id[8 +: 4] = 4'($urandom);
      if (x_origin !== 8'd33 || y_origin !== 9'd44 || rom_id !== 4'd5) bad++;
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (bad != 0 || x_origin !== 8'd33) begin
      n_fail++;
      $display("FAIL churn_latch: %0d bad cycles x=%0d, required 0 and 33", bad, x_origin);
    end
    req = 4'b0000;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_slow_engine();
    test_timeout();
    test_round_robin();
    test_reset_mid_draw();
    test_input_churn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
